// File: rtl/fec_link_bringup_ctrl.sv
// Link bring-up sequencer: GT reset, bit lock, frame lock, PRBS verification,
// bounded retries with backoff, and continuous lock supervision once up.
module fec_link_bringup_ctrl #(
  parameter int unsigned GT_RST_CYCLES  = 64,
  parameter int unsigned BIT_TO         = 200000,
  parameter int unsigned FRAME_TO       = 200000,
  parameter int unsigned PRBS_TO        = 400000,
  parameter int unsigned STABLE_CYCLES  = 100000,
  parameter int unsigned BACKOFF_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TW             = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bit_locked,
  input  logic        frame_locked,
  input  logic        prbs_meas_ok,
  input  logic [7:0]  prbs_err_vec,
  output logic        gt_rst,
  output logic        prbs_clr,
  output logic        link_up,
  output logic        link_fail,
  output logic        lock_lost,
  output logic [3:0]  state,
  output logic [1:0]  retry_cnt,
  output logic [15:0] relock_cnt
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_GT_RST     = 4'd1,
    S_WAIT_BIT   = 4'd2,
    S_WAIT_FRAME = 4'd3,
    S_WAIT_PRBS  = 4'd4,
    S_VERIFY     = 4'd5,
    S_LINK_UP    = 4'd6,
    S_BACKOFF    = 4'd7,
    S_FAIL       = 4'd8
  } state_t;

  localparam logic [TW-1:0] GT_RST_LAST  = TW'(GT_RST_CYCLES - 1);
  localparam logic [TW-1:0] BIT_LAST     = TW'(BIT_TO - 1);
  localparam logic [TW-1:0] FRAME_LAST   = TW'(FRAME_TO - 1);
  localparam logic [TW-1:0] PRBS_LAST    = TW'(PRBS_TO - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [1:0]    MAX_R        = 2'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    retry_q, retry_d;
  logic [15:0]   relock_q, relock_d;
  logic          gt_rst_q, gt_rst_d;
  logic          prbs_clr_q, prbs_clr_d;
  logic          link_up_q, link_up_d;
  logic          link_fail_q, link_fail_d;
  logic          lock_lost_q, lock_lost_d;

  logic prbs_good;
  logic prbs_bad;
  logic fault;

  assign prbs_good = prbs_meas_ok & (prbs_err_vec == 8'd0);
  assign prbs_bad  = prbs_meas_ok & (prbs_err_vec != 8'd0);

  // Next-state, counters and registered-output values
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    relock_d    = relock_q;
    lock_lost_d = 1'b0;
    fault       = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_GT_RST;
        S_GT_RST: if (timer_q == GT_RST_LAST) state_d = S_WAIT_BIT;
        S_WAIT_BIT: begin
          if (bit_locked)                 state_d = S_WAIT_FRAME;
          else if (timer_q == BIT_LAST)   fault   = 1'b1;
        end
        S_WAIT_FRAME: begin
          if (!bit_locked)                fault   = 1'b1;
          else if (frame_locked)          state_d = S_WAIT_PRBS;
          else if (timer_q == FRAME_LAST) fault   = 1'b1;
        end
        S_WAIT_PRBS: begin
          if (!bit_locked || !frame_locked) fault   = 1'b1;
          else if (prbs_good)               state_d = S_VERIFY;
          else if (timer_q == PRBS_LAST)    fault   = 1'b1;
        end
        S_VERIFY: begin
          if (!prbs_good || !bit_locked || !frame_locked) fault   = 1'b1;
          else if (timer_q == STABLE_LAST)                state_d = S_LINK_UP;
        end
        S_LINK_UP: begin
          if (!bit_locked || !frame_locked || prbs_bad) begin
            state_d     = S_BACKOFF;
            lock_lost_d = 1'b1;
            if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
          end
        end
        S_BACKOFF: if (timer_q == BACKOFF_LAST) state_d = S_GT_RST;
        S_FAIL:    state_d = S_FAIL;
        default:   state_d = S_IDLE;
      endcase
    end

    if (fault) begin
      if (retry_q == MAX_R) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = S_BACKOFF;
      end
    end

    // Retry count restarts whenever the link comes up or the block idles
    if (state_d == S_IDLE || (state_d == S_LINK_UP && state_q != S_LINK_UP))
      retry_d = '0;

    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);

    gt_rst_d    = (state_d == S_IDLE) || (state_d == S_GT_RST) ||
                  (state_d == S_BACKOFF) || (state_d == S_FAIL);
    prbs_clr_d  = (state_d == S_LINK_UP) && (state_q != S_LINK_UP);
    link_up_d   = (state_d == S_LINK_UP);
    link_fail_d = (state_d == S_FAIL);
  end

  // State, timer, counters and outputs register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      gt_rst_q    <= 1'b1;
      prbs_clr_q  <= 1'b0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      gt_rst_q    <= gt_rst_d;
      prbs_clr_q  <= prbs_clr_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign gt_rst     = gt_rst_q;
  assign prbs_clr   = prbs_clr_q;
  assign link_up    = link_up_q;
  assign link_fail  = link_fail_q;
  assign lock_lost  = lock_lost_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_fec_link_bringup_ctrl.sv
// Scoreboard bench for fec_link_bringup_ctrl: a reference model pushes the
// expected outputs of each cycle, a negedge monitor pops and compares.
module tb_fec_link_bringup_ctrl;

  localparam int GTR = 8;
  localparam int TO  = 50;
  localparam int STB = 20;
  localparam int BOF = 5;
  localparam int MR  = 3;

  localparam int P_IDLE = 0, P_GTR = 1, P_WB = 2, P_WF = 3, P_WP = 4,
                 P_VER = 5, P_LU = 6, P_BO = 7, P_FAIL = 8;

  logic        clk = 1'b0;
  logic        rst, en, bit_locked, frame_locked, prbs_meas_ok;
  logic [7:0]  prbs_err_vec;
  logic        gt_rst, prbs_clr, link_up, link_fail, lock_lost;
  logic [3:0]  state;
  logic [1:0]  retry_cnt;
  logic [15:0] relock_cnt;

  fec_link_bringup_ctrl #(
    .GT_RST_CYCLES(GTR), .BIT_TO(TO), .FRAME_TO(TO), .PRBS_TO(TO),
    .STABLE_CYCLES(STB), .BACKOFF_CYCLES(BOF), .MAX_RETRIES(MR), .TW(24)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bit_locked(bit_locked),
    .frame_locked(frame_locked), .prbs_meas_ok(prbs_meas_ok),
    .prbs_err_vec(prbs_err_vec), .gt_rst(gt_rst), .prbs_clr(prbs_clr),
    .link_up(link_up), .link_fail(link_fail), .lock_lost(lock_lost),
    .state(state), .retry_cnt(retry_cnt), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit gt, clr, up, fail, lost;
    int retry;
    int relock;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_ph = P_IDLE, m_age = 0, m_retry = 0, m_relock = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: advances one cycle on each edge from the sampled inputs
  initial begin : model
    int  nph;
    bit  good, fault, lost, clr;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = P_IDLE; m_age = 0; m_retry = 0; m_relock = 0;
        e = '{st: P_IDLE, gt: 1'b1, clr: 1'b0, up: 1'b0, fail: 1'b0, lost: 1'b0, retry: 0, relock: 0};
      end else begin
        good  = prbs_meas_ok && (prbs_err_vec == 0);
        nph   = m_ph;
        fault = 0;
        lost  = 0;
        if (!en) nph = P_IDLE;
        else case (m_ph)
          P_IDLE: nph = P_GTR;
          P_GTR:  if (m_age == GTR - 1) nph = P_WB;
          P_WB:   if (bit_locked) nph = P_WF; else if (m_age == TO - 1) fault = 1;
          P_WF:   if (!bit_locked) fault = 1;
                  else if (frame_locked) nph = P_WP;
                  else if (m_age == TO - 1) fault = 1;
          P_WP:   if (!bit_locked || !frame_locked) fault = 1;
                  else if (good) nph = P_VER;
                  else if (m_age == TO - 1) fault = 1;
          P_VER:  if (!good || !bit_locked || !frame_locked) fault = 1;
                  else if (m_age == STB - 1) nph = P_LU;
          P_LU:   if (!bit_locked || !frame_locked || (prbs_meas_ok && prbs_err_vec != 0)) begin
                    lost = 1;
                    nph  = P_BO;
                    if (m_relock < 65535) m_relock++;
                  end
          P_BO:   if (m_age == BOF - 1) nph = P_GTR;
          default: ;
        endcase
        if (fault) begin
          if (m_retry == MR) nph = P_FAIL;
          else begin m_retry++; nph = P_BO; end
        end
        clr = (nph == P_LU) && (m_ph != P_LU);
        if (nph == P_IDLE || clr) m_retry = 0;
        m_age = (nph == m_ph) ? m_age + 1 : 0;
        m_ph  = nph;
        e = '{st: m_ph, gt: (m_ph == P_IDLE || m_ph == P_GTR || m_ph == P_BO || m_ph == P_FAIL),
              clr: clr, up: (m_ph == P_LU), fail: (m_ph == P_FAIL), lost: lost,
              retry: m_retry, relock: m_relock};
      end
      expq.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("state",      32'(state),      32'(e.st));
        chk("gt_rst",     32'(gt_rst),     32'(e.gt));
        chk("prbs_clr",   32'(prbs_clr),   32'(e.clr));
        chk("link_up",    32'(link_up),    32'(e.up));
        chk("link_fail",  32'(link_fail),  32'(e.fail));
        chk("lock_lost",  32'(lock_lost),  32'(e.lost));
        chk("retry_cnt",  32'(retry_cnt),  32'(e.retry));
        chk("relock_cnt", 32'(relock_cnt), 32'(e.relock));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_model(input int ph, input int age, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (m_ph == ph && (age < 0 || m_age == age)) return;
    end
    n_checks++;
    $display("FAIL wait_%s: phase %0d age %0d not reached within %0d cycles", tag, ph, age, budget);
  endtask

  initial begin : stim
    int n;
    int p;
    rst = 1; en = 0; bit_locked = 1; frame_locked = 1; prbs_meas_ok = 1; prbs_err_vec = 8'h00;
    tick(3);
    rst = 0;
    tick(2);

    // Happy path: link_up 32 cycles after en rises
    en = 1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      n++;
      if (link_up === 1'b1) break;
    end
    chk("happy_latency", 32'(n), 32'd32);
    tick(5);

    // Link drop in LINK_UP then relink
    frame_locked = 0; tick(1); frame_locked = 1;
    wait_model(P_LU, -1, 200, "relink");
    tick(3);

    // VERIFY glitch at timer 10, then clean retry
    en = 0; tick(2); en = 1;
    wait_model(P_VER, 10, 200, "verify10");
    prbs_err_vec = 8'h04; tick(1); prbs_err_vec = 8'h00;
    wait_model(P_LU, -1, 300, "glitch_relink");
    tick(2);

    // No bit lock: retries exhaust into FAIL, en=0 returns to IDLE
    en = 0; tick(2);
    bit_locked = 0; en = 1;
    wait_model(P_FAIL, -1, 1000, "fail");
    tick(10);
    en = 0; tick(3);
    bit_locked = 1;

    // Success at the last timeout cycle, then en=0 together with success
    bit_locked = 0; frame_locked = 0; en = 1;
    wait_model(P_WB, 49, 200, "wb49");
    bit_locked = 1; tick(1);
    en = 0; frame_locked = 1; tick(3);

    // Reset in the middle of VERIFY
    en = 1;
    wait_model(P_VER, 5, 200, "verify5");
    rst = 1; tick(1); rst = 0;
    tick(3);

    // Randomised segments of varying link quality
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0: p = 0;
        1: p = 950;
        2: p = 995;
        default: p = 1000;
      endcase
      repeat ($urandom_range(20, 150)) begin
        rst          = ($urandom_range(0, 499) == 0);
        en           = ($urandom_range(0, 299) != 0);
        bit_locked   = ($urandom_range(0, 999) < p) || (p == 0 && $urandom_range(0, 1) == 0);
        frame_locked = ($urandom_range(0, 999) < p);
        prbs_meas_ok = ($urandom_range(0, 99) < 95);
        prbs_err_vec = ($urandom_range(0, 999) < p) ? 8'h00 : 8'($urandom_range(1, 255));
        tick(1);
      end
    end
    rst = 0; en = 0;
    tick(3);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
